// File: rtl/sel_mux_reg.sv
// sel_mux_reg: N-input, W-bit registered multiplexer with valid/ready on
// every channel and a one-entry output register. MODE 0 passes the channel
// named by sel; MODE 1 arbitrates round-robin starting from an internal ptr.

// Per-channel request qualification. Each lane decides whether its channel
// is competing this cycle, and whether it sits at or above the round-robin
// pointer (first search pass).
module sel_mux_lane #(
    parameter int SEL_W = 2,
    parameter int MODE  = 0,
    parameter int IDX   = 0
) (
    input  logic             valid,
    input  logic [SEL_W-1:0] sel,
    input  logic [SEL_W-1:0] ptr,
    output logic             req,
    output logic             hi
);
    localparam logic [SEL_W-1:0] IDX_W = SEL_W'(IDX);

    // In explicit mode only the addressed channel competes; an out-of-range
    // sel matches no lane and therefore never grants.
    assign req = (MODE == 0) ? (valid && (sel == IDX_W)) : valid;
    assign hi  = (IDX_W >= ptr);
endmodule

module sel_mux_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);
    logic             accept;
    logic             xfer;
    logic [SEL_W-1:0] ptr;
    logic [NUM_IN-1:0] req;
    logic [NUM_IN-1:0] hi;
    logic             gnt_any;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] sel_data;

    // Register can take a word when empty or when it is draining this cycle.
    assign accept = !out_valid || out_ready;
    assign xfer   = |in_ready;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
        sel_mux_lane #(
            .SEL_W (SEL_W),
            .MODE  (MODE),
            .IDX   (g)
        ) u_lane (
            .valid (in_valid[g]),
            .sel   (sel),
            .ptr   (ptr),
            .req   (req[g]),
            .hi    (hi[g])
        );
    end

    // Rotating priority: lowest requester at/above ptr wins; if none, lowest
    // requester overall (the wrapped second pass). Loops run high-to-low so
    // the last hit is the lowest index.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_any = 1'b1;
                gnt_idx = SEL_W'(i);
            end
        end
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (req[i] && hi[i]) begin
                gnt_idx = SEL_W'(i);
            end
        end
    end

    // One-hot ready for the granted channel and the matching data word.
    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = accept && gnt_any && !rst;
            end
        end
    end

    // Output register and round-robin pointer; empties on a drain with no
    // new word, holds everything on a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= gnt_idx;
                if (MODE == 1) begin
                    ptr <= (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/sel_mux_reg.md
# sel_mux_reg

Parametrised N-input, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It is the general successor to the 32-bit 2-to-1 mux used throughout the datapath. It adds:
- any channel count and width;
- an explicit-select mode or a round-robin arbitration mode;
- a one-entry output register, so the block can sit between pipeline stages (writeback source select, shared memory-port merge).

## Interface
- WIDTH, 32, data width of each channel
- NUM_IN, 4, number of input channels (2..16)
- SEL_W, 2, select/source index width; must satisfy 2^SEL_W >= NUM_IN
- MODE, 0, 0 = explicit select via `sel`; 1 = round-robin arbitration (`sel` ignored)

Ports:
- clk  input  1  rising-edge clock; one clock domain
- rst  input  1  reset; synchronous, active-high
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  channel i presents a word
- in_ready  output  NUM_IN  channel i word is taken this cycle; combinational
- sel  input  SEL_W  channel to pass in MODE 0
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  out_data holds a word
- out_ready  input  1  downstream takes out_data this cycle
- out_src  output  SEL_W  index of the channel that supplied out_data

## Operation
- Transfer rule: a transfer occurs on any interface in a cycle where valid and ready are both 1 at the rising edge.
- Register state:
  - `accept = !out_valid || out_ready`.
  - The output register can load in any cycle where accept is 1, including a drain and a load in the same cycle.
- Grant, MODE 0:
  - grant = sel when sel < NUM_IN and in_valid[sel] = 1; otherwise no grant.
  - Valid bits of unselected channels are ignored.
  - sel >= NUM_IN never grants.
- Grant, MODE 1:
  - An internal pointer ptr (SEL_W bits, reset 0) sets the search order.
  - grant = first i with in_valid[i] = 1, searching ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1.
  - No grant when all valid bits are 0.
- Outputs:
  - in_ready[i] = accept && (a grant exists) && grant == i.
  - At most one in_ready bit is high per cycle.
  - in_ready must not depend on out_valid except through accept, and must not depend on in_ready itself.
- On a transfer from channel g:
  - out_data <= in_data[g]
  - out_src <= g
  - out_valid <= 1
  - MODE 1 only: ptr <= (g+1) mod NUM_IN. Wrap from NUM_IN-1 goes to 0, not to 2^SEL_W-1.
- Drain with no grant: out_valid <= 0; out_data and out_src hold their values.
- Stall (out_valid = 1, out_ready = 0):
  - out_data, out_src and ptr hold.
  - All in_ready bits are 0.
- No arithmetic on data; words pass bit-exact.

## Timing
- Reset (rst sampled high at an edge):
  - out_valid = 0, out_data = 0, out_src = 0, ptr = 0.
  - Effective the cycle after the edge, and applies even mid-transfer.
  - A word accepted in the same cycle as reset is discarded.
  - in_ready = 0 while rst is high.
- Latency: input transfer at edge N makes out_valid = 1 with that word after edge N, visible in cycle N+1.
- Throughput: one word per cycle sustained while out_ready = 1.
- Combinational paths:
  - in_valid / sel / out_ready -> in_ready.
  - No combinational path from any input to out_data, out_valid or out_src.
- Fairness (MODE 1): with all channels continuously valid and out_ready = 1, channel grants are issued 0,1,…,NUM_IN-1,0,… with no channel skipped or repeated.

## Test plan
- Reset
  - Stimulus: drive rst = 1 with out_valid = 1 and all in_valid = 1.
  - Required response: next cycle out_valid = 0, out_data = 0, out_src = 0, and in_ready = 0000 while rst is high.
- MODE 0 passthrough
  - Stimulus: NUM_IN = 4, sel = 2, in_valid = 1111, in_data[2] = 0xDEADBEEF, out_ready = 1.
  - Required response: in_ready = 0100; next cycle out_data = 0xDEADBEEF, out_src = 2; an illegal sel = 3 on a NUM_IN = 3 build gives in_ready = 000.
- Backpressure
  - Stimulus: load word 0x11, hold out_ready = 0 for 3 cycles while in_valid[sel] = 1 with word 0x22.
  - Required response: out_data stays 0x11 and in_ready = 0 for all 3 cycles; raising out_ready gives 0x22 the next cycle with no bubble and no loss.
- MODE 1 rotation
  - Stimulus: NUM_IN = 4, in_valid = 1111 held, out_ready = 1.
  - Required response: out_src sequence 0,1,2,3,0,1.
- MODE 1 skip and wrap
  - Stimulus: in_valid = 1001 held, out_ready = 1.
  - Required response: out_src alternates 0,3,0,3; after a grant of 3, ptr wraps to 0.
- Empty drain
  - Stimulus: one word output, then in_valid = 0000 with out_ready = 1.
  - Required response: out_valid falls to 0 after one cycle; out_data keeps its last value.
